// File: rtl/prga_prog_loader_if.sv
// Wishbone slave bus bundle for the PRGA bitstream loader.
interface prga_prog_loader_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/prga_prog_loader.sv
// Wishbone-fed bitstream loader: FIFO of 32-bit words serialized MSB-first onto the
// PRGA programming chain. Optional readback register: define PRGA_PROG_READBACK_EN.
module prga_prog_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CLK_DIV    = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  prga_prog_loader_if.slave  wbs,
  output logic               prog_clk,
  output logic               prog_rst,
  output logic               prog_done,
  output logic               prog_we,
  output logic               prog_din,
  input  logic               prog_dout,
  input  logic               prog_we_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, LO, HI} state_t;
  state_t state;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   shreg, bitcnt, rb_rd, rdata;
  logic [5:0]    bidx;
  logic [DW-1:0] div;

  logic       hit, wr, ctrl_wr, rst_nxt, flush, push, push_ok, pop;
  logic       empty, full, busy, div_last;
  logic [2:0] off;
  logic [3:0] level;
  logic       unused;

  assign hit      = wbs.cyc && wbs.stb && !wbs.ack && (wbs.adr[31:5] == BASE_ADDR[31:5]);
  assign wr       = hit && wbs.we;
  assign off      = wbs.adr[4:2];
  assign ctrl_wr  = wr && (off == 3'd0) && wbs.sel[0];
  // Next-cycle prog_rst, so abort/clear take effect on the same edge as the write
  assign rst_nxt  = ctrl_wr ? wbs.dat_w[0] : prog_rst;
  assign flush    = ctrl_wr && (wbs.dat_w[2] || (wbs.dat_w[0] && !prog_rst));
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign busy     = (state != IDLE) || !empty;
  assign pop      = (state == IDLE) && !empty && !rst_nxt;
  assign push     = wr && (off == 3'd2);
  assign push_ok  = push && (!full || pop);
  assign div_last = (div == DW'(CLK_DIV - 1));
  assign level    = 4'(count);
  assign unused   = ^{wbs.sel[3:1], wbs.adr[1:0]};

  always_ff @(posedge wb_clk_i)
    if (push_ok) mem[wr_ptr] <= wbs.dat_w;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop);
      end
      if (ctrl_wr && wbs.dat_w[3])  overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prog_rst  <= 1'b1;
      prog_done <= 1'b0;
    end else begin
      prog_rst <= rst_nxt;
      if (ctrl_wr) prog_done <= wbs.dat_w[1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      prog_clk <= 1'b0;
      prog_we  <= 1'b0;
      prog_din <= 1'b0;
      shreg    <= '0;
      bidx     <= '0;
      div      <= '0;
      bitcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          prog_clk <= 1'b0;
          prog_we  <= 1'b0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            bidx  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          div      <= '0;
          prog_clk <= 1'b0;
          prog_we  <= 1'b1;
          prog_din <= shreg[31];
          state    <= LO;
        end
        LO: begin
          if (div_last) begin
            div      <= '0;
            prog_clk <= 1'b1;
            state    <= HI;
          end else div <= div + 1'b1;
        end
        HI: begin
          if (div_last) begin
            div      <= '0;
            shreg    <= {shreg[30:0], 1'b0};
            bidx     <= bidx + 1'b1;
            bitcnt   <= bitcnt + 1'b1;
            prog_clk <= 1'b0;
            if (bidx == 6'd31) begin
              prog_we <= 1'b0;
              state   <= IDLE;
            end else begin
              prog_din <= shreg[30];
              state    <= LO;
            end
          end else div <= div + 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (rst_nxt && state != IDLE) begin
        state    <= IDLE;
        prog_clk <= 1'b0;
        prog_we  <= 1'b0;
      end
      if (rst_nxt) bitcnt <= '0;
    end
  end

`ifdef PRGA_PROG_READBACK_EN
  logic [31:0] rb;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || rst_nxt)         rb <= '0;
    else if (state == HI && div_last) rb <= {rb[30:0], prog_dout};
  end
  assign rb_rd = rb;
`else
  assign rb_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata[1:0] = {prog_done, prog_rst};
      3'd1: rdata[9:0] = {prog_dout, prog_we_o, level, overflow, empty, full, busy};
      3'd3: rdata      = bitcnt;
      3'd4: rdata      = rb_rd;
      default: rdata   = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs.ack   <= 1'b0;
      wbs.dat_r <= '0;
    end else begin
      wbs.ack   <= hit;
      wbs.dat_r <= (hit && !wbs.we) ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_prga_prog_loader.sv
// Randomized self-checking bench for prga_prog_loader against a queue-based bitstream model.
module tb_prga_prog_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int CD = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] CTRL = 32'h00, STATUS = 32'h04, DATA = 32'h08, BITCNT = 32'h0C, RDBK = 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_clk, prog_rst, prog_done, prog_we, prog_din;
  logic prog_dout = 1'b0;
  logic prog_we_o = 1'b0;

  prga_prog_loader_if wb();

  prga_prog_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (wb),
    .prog_clk (prog_clk),
    .prog_rst (prog_rst),
    .prog_done(prog_done),
    .prog_we  (prog_we),
    .prog_din (prog_din),
    .prog_dout(prog_dout),
    .prog_we_o(prog_we_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cap_q[$];
  bit exp_q[$];
  int rise_q[$];
  int cyc_n = 0;
  int we_cyc = 0;
  bit din_glitch = 0;
  bit rb_loop = 0;
  logic last_din = 1'b0;
  logic prev_clk = 1'b0, prev_we = 1'b0, prev_din = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;
  always @(posedge prog_clk) begin
    cap_q.push_back(prog_din);
    if (rb_loop) begin
      prog_dout = last_din;
      last_din  = prog_din;
    end
  end
  // prog_din may only move while prog_clk is low
  always @(negedge clk) begin
    if (prog_we) we_cyc++;
    if (prog_we && !prev_we) rise_q.push_back(cyc_n);
    if (prog_clk && prev_clk && prog_din !== prev_din) din_glitch = 1;
    prev_clk = prog_clk;
    prev_we  = prog_we;
    prev_din = prog_din;
  end

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] data,
                         input logic [3:0] sel, input bit exp_ack, output logic [31:0] rdata);
    logic [31:0] lat;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.sel = sel; wb.adr = addr; wb.dat_w = data;
    lat = 32'hFFFF_FFFF;
    rdata = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (wb.ack) begin
        lat = 32'(i);
        rdata = wb.dat_r;
        break;
      end
      if (!exp_ack) chk("dat_idle", wb.dat_r, 32'h0);
    end
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    chk("ack_lat", lat, exp_ack ? 32'd1 : 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, wb.ack}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] d;
    wb_xfer(BASE + off, 1'b1, data, 4'hF, 1'b1, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(BASE + off, 1'b0, 32'h0, 4'hF, 1'b1, d);
    chk(tag, d, exp);
  endtask

  task automatic exp_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic clear_mon();
    cap_q.delete(); exp_q.delete(); rise_q.delete();
    we_cyc = 0;
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic cmp_bits(input string tag);
    int bad = 0;
    int n;
    chk({tag, "_nbits"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) bad++;
    chk({tag, "_bits"}, 32'(bad), 32'h0);
  endtask

  initial begin
    logic [31:0] w, d;
    int n0, nw;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 4'h0; wb.adr = '0; wb.dat_w = '0;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_prog_rst", {31'b0, prog_rst}, 32'h1);
    chk("rst_prog_done", {31'b0, prog_done}, 32'h0);
    chk("rst_outs", {29'b0, prog_clk, prog_we, prog_din}, 32'h0);
    chk("rst_ack", {31'b0, wb.ack}, 32'h0);
    rd_chk("rst_status", STATUS, 32'h0000_0004);
    rd_chk("rst_bitcnt", BITCNT, 32'h0);

    // CTRL byte-0 select gating
    wb_xfer(BASE + CTRL, 1'b1, 32'h2, 4'b1110, 1'b1, d);
    rd_chk("ctrl_sel_ignored", CTRL, 32'h1);
    wr(CTRL, 32'h3);
    rd_chk("ctrl_rw", CTRL, 32'h3);
    chk("prog_done_pin", {31'b0, prog_done}, 32'h1);
    wr(CTRL, 32'h1);

    // unmatched addresses
    wb_xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, d);
    wb_xfer(32'h1000_0004, 1'b1, 32'h0, 4'hF, 1'b0, d);

    // single word
    clear_mon();
    wr(CTRL, 32'h0);
    wr(DATA, 32'hA500_0001);
    exp_word(32'hA500_0001);
    wait_bits(32, 400);
    cmp_bits("single");
    chk("single_we_cyc", 32'(we_cyc), 32'(32 * 2 * CD));
    rd_chk("single_bitcnt", BITCNT, 32'd32);
    rd_chk("single_status", STATUS, 32'h0000_0004);

    // overflow with programming held in reset
    wr(CTRL, 32'h1);
    clear_mon();
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      wr(DATA, w);
      if (i < DEPTH) exp_word(w);
    end
    rd_chk("ovf_status", STATUS, 32'h0000_004B);
    chk("ovf_idle_outs", {30'b0, prog_clk, prog_we}, 32'h0);
    wr(CTRL, 32'h0);
    wait_bits(32 * DEPTH, 1200);
    cmp_bits("ovf_drain");
    chk("ovf_we_cyc", 32'(we_cyc), 32'(DEPTH * 64 * CD));
    rd_chk("ovf_bitcnt", BITCNT, 32'(32 * DEPTH));
    rd_chk("ovf_sticky", STATUS, 32'h0000_000C);
    wr(CTRL, 32'h8);
    rd_chk("ovf_cleared", STATUS, 32'h0000_0004);

    // back-to-back words: word period is 1 + 64*CLK_DIV plus one idle cycle
    wr(CTRL, 32'h1);
    wr(CTRL, 32'h0);
    clear_mon();
    wr(DATA, 32'hFFFF_FFFF);
    wr(DATA, 32'h0000_0000);
    exp_word(32'hFFFF_FFFF);
    exp_word(32'h0000_0000);
    wait_bits(64, 600);
    cmp_bits("b2b");
    chk("b2b_nrise", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() >= 2) chk("b2b_period", 32'(rise_q[1] - rise_q[0]), 32'(2 + 64 * CD));
    chk("b2b_we_cyc", 32'(we_cyc), 32'(128 * CD));
    rd_chk("b2b_bitcnt", BITCNT, 32'd64);

    // abort mid-word with words queued
    clear_mon();
    w = $urandom;
    wr(DATA, w);
    wr(DATA, $urandom);
    wr(DATA, $urandom);
    n0 = 0;
    while (cap_q.size() < 10 && n0 < 400) begin
      @(posedge clk);
      n0++;
    end
    wr(CTRL, 32'h1);
    chk("abort_outs", {30'b0, prog_clk, prog_we}, 32'h0);
    n0 = cap_q.size();
    rd_chk("abort_status", STATUS, 32'h0000_0004);
    rd_chk("abort_bitcnt", BITCNT, 32'h0);
    repeat (300) @(posedge clk);
    #1;
    chk("abort_no_edges", 32'(cap_q.size()), 32'(n0));
    exp_word(w);
    nw = 0;
    for (int i = 0; i < cap_q.size() && i < 32; i++) if (cap_q[i] !== exp_q[i]) nw++;
    chk("abort_prefix", 32'(nw), 32'h0);

    // readback
`ifdef PRGA_PROG_READBACK_EN
    wr(CTRL, 32'h0);
    clear_mon();
    rb_loop = 1;
    wr(DATA, 32'h1234_5678);
    wait_bits(32, 400);
    rb_loop = 0;
    prog_dout = 1'b0;
    rd_chk("readback", RDBK, 32'h091A_2B3C);
    wr(CTRL, 32'h1);
`else
    rd_chk("readback_off", RDBK, 32'h0);
`endif

    // randomized word batches
    for (int r = 0; r < 3; r++) begin
      wr(CTRL, 32'h1);
      clear_mon();
      nw = $urandom_range(1, DEPTH);
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        wr(DATA, w);
        exp_word(w);
      end
      wr(CTRL, 32'h0);
      wait_bits(32 * nw, 150 * nw + 50);
      cmp_bits("rand");
      chk("rand_we_cyc", 32'(we_cyc), 32'(nw * 64 * CD));
      rd_chk("rand_bitcnt", BITCNT, 32'(32 * nw));
    end

    // bus reset mid-word
    clear_mon();
    wr(DATA, $urandom);
    n0 = 0;
    while (cap_q.size() < 5 && n0 < 200) begin
      @(posedge clk);
      n0++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("wbrst_prog_rst", {31'b0, prog_rst}, 32'h1);
    chk("wbrst_outs", {28'b0, prog_done, prog_clk, prog_we, prog_din}, 32'h0);
    rd_chk("wbrst_status", STATUS, 32'h0000_0004);
    rd_chk("wbrst_bitcnt", BITCNT, 32'h0);

    chk("din_stable_hi", {31'b0, din_glitch}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
